// File: rtl/seg_scan_scheduler.sv
// Eight-digit 7-segment scan sequencer: per-digit slot with a blanking gap,
// PWM dimming inside the slot, and skipping of masked-off digits.
module seg_scan_scheduler #(
  parameter int unsigned SLOT_CYC  = 208333,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] en_mask,
  input  logic [3:0] bright,
  output logic [7:0] a,
  output logic [2:0] seg_sel,
  output logic       blank,
  output logic       frame
);

  localparam int unsigned STEP = (SLOT_CYC - BLANK_CYC) / 16;

  typedef enum logic [1:0] {IDLE, BLANK, ON, DARK} state_t;

  state_t      state;
  logic [17:0] cnt;
  logic [7:0]  m_r;
  logic [3:0]  b_r;
  logic [31:0] cnt_w;
  logic [31:0] on_len;
  logic [31:0] on_last;
  logic        slot_last;
  logic        blank_last;
  logic        on_done;
  logic [2:0]  first_sel;
  logic [2:0]  next_sel;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[i] && !found) begin
        lowest_set = 3'(i);
        found      = 1'b1;
      end
    end
  endfunction

  // Circular search starting just after cur; the final step (i=8) lands on cur
  // itself, so a mask holding only the current digit keeps it selected.
  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    logic       found;
    logic [2:0] idx;
    next_set = cur;
    found    = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      idx = cur + 3'(i);
      if (m[idx] && !found) begin
        next_set = idx;
        found    = 1'b1;
      end
    end
  endfunction

  assign cnt_w      = {14'd0, cnt};
  assign on_len     = 32'(b_r) * STEP;
  assign on_last    = BLANK_CYC + on_len - 32'd1;
  assign slot_last  = (cnt_w == SLOT_CYC - 32'd1);
  assign blank_last = (cnt_w == BLANK_CYC - 32'd1);
  assign on_done    = (cnt_w == on_last);
  assign first_sel  = lowest_set(en_mask);
  assign next_sel   = next_set(m_r, seg_sel);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      m_r     <= '0;
      b_r     <= '0;
      a       <= '1;
      seg_sel <= '0;
      blank   <= 1'b1;
      frame   <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        a     <= '1;
        blank <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            a     <= '1;
            blank <= 1'b1;
            if (en_mask != '0) begin
              state   <= BLANK;
              seg_sel <= first_sel;
              frame   <= 1'b1;
              m_r     <= en_mask;
              b_r     <= bright;
            end
          end
          BLANK: begin
            cnt <= cnt + 18'd1;
            if (blank_last) begin
              if (on_len != '0) begin
                state <= ON;
                a     <= ~(8'd1 << seg_sel);
                blank <= 1'b0;
              end else begin
                state <= DARK;
              end
            end
          end
          ON, DARK: begin
            // Slot end takes priority so a full-window ON goes straight to the next slot.
            if (slot_last) begin
              a     <= '1;
              blank <= 1'b1;
              cnt   <= '0;
              if (m_r == '0) begin
                state <= IDLE;
              end else begin
                state   <= BLANK;
                seg_sel <= next_sel;
                frame   <= (next_sel <= seg_sel);
                m_r     <= en_mask;
                b_r     <= bright;
              end
            end else if (state == ON && on_done) begin
              state <= DARK;
              a     <= '1;
              blank <= 1'b1;
              cnt   <= cnt + 18'd1;
            end else begin
              cnt <= cnt + 18'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench for seg_scan_scheduler: a slot-position reference model pushes
// expected outputs every clock; a monitor pops and compares on the falling edge.
module tb_seg_scan_scheduler;

  localparam int SLOT = 64;
  localparam int BLK  = 16;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       enable  = 1'b0;
  logic [7:0] en_mask = 8'h00;
  logic [3:0] bright  = 4'd0;
  logic [7:0] a;
  logic [2:0] seg_sel;
  logic       blank;
  logic       frame;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [2:0] sel;
    logic       blank;
    logic       frame;
  } obs_t;

  obs_t exp_q[$];

  seg_scan_scheduler #(.SLOT_CYC(SLOT), .BLANK_CYC(BLK)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .en_mask (en_mask),
    .bright  (bright),
    .a       (a),
    .seg_sel (seg_sel),
    .blank   (blank),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  // Reference model: running flag, position within slot, current digit,
  // latched mask/brightness, frame flag.
  bit         run = 0;
  int         p   = 0;
  int         d   = 0;
  logic [7:0] m   = 8'h00;
  int         b   = 0;
  bit         fr  = 0;

  function automatic int lowest_bit(input logic [7:0] x);
    for (int i = 0; i < 8; i++) if (x[i]) return i;
    return 0;
  endfunction

  function automatic int next_bit(input logic [7:0] x, input int cur);
    for (int k = 1; k <= 8; k++) if (x[(cur + k) % 8]) return (cur + k) % 8;
    return cur;
  endfunction

  always @(posedge clk) begin
    obs_t e;
    int   nd;
    bit   lit;
    if (!reset) begin
      run = 0; p = 0; d = 0; fr = 0;
    end else if (!enable) begin
      run = 0; p = 0; fr = 0;
    end else if (!run) begin
      fr = 0;
      if (en_mask != 8'h00) begin
        run = 1; p = 0; d = lowest_bit(en_mask);
        m = en_mask; b = int'(bright); fr = 1;
      end
    end else if (p == SLOT - 1) begin
      if (m == 8'h00) begin
        run = 0; p = 0; fr = 0;
      end else begin
        nd = next_bit(m, d);
        fr = (nd <= d);
        d  = nd;
        m  = en_mask; b = int'(bright); p = 0;
      end
    end else begin
      p++; fr = 0;
    end
    lit     = run && (p >= BLK) && (p < BLK + b * ((SLOT - BLK) / 16));
    e.a     = lit ? ~(8'd1 << d) : 8'hFF;
    e.sel   = 3'(d);
    e.blank = !lit;
    e.frame = fr;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e;
    obs_t got;
    got = {a, seg_sel, blank, frame};
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL queue_underflow t=%0t got a=%h sel=%0d required an expected entry", $time, a, seg_sel);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failed++;
        $display("FAIL cycle_outputs t=%0t got a=%h sel=%0d blank=%b frame=%b required a=%h sel=%0d blank=%b frame=%b",
                 $time, a, seg_sel, blank, frame, e.a, e.sel, e.blank, e.frame);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_lit(input string tag);
    int k = 0;
    while (a == 8'hFF && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (a == 8'hFF) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout got a=%h required a lit anode within 300 cycles", tag, a);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
    tests++;
    if (got !== req) begin
      failed++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  initial begin
    step(3);
    reset = 1'b1; enable = 1'b1; en_mask = 8'hFF; bright = 4'd8;
    step(1100);

    en_mask = 8'b1010_0100; bright = 4'd15;
    step(600);

    en_mask = 8'h08;
    step(300);

    en_mask = 8'h41; bright = 4'd15;
    step(100);
    wait_lit("bright_change");
    step(5);
    bright = 4'd2;
    step(200);

    en_mask = 8'h3C; bright = 4'd9;
    step(100);
    wait_lit("enable_drop");
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(250);

    wait_lit("async_reset");
    #1 reset = 1'b0;
    #1;
    chk("async_a", a, 8'hFF);
    chk("async_seg_sel", {5'd0, seg_sel}, 8'h00);
    chk("async_frame", {7'd0, frame}, 8'h00);
    chk("async_blank", {7'd0, blank}, 8'h01);
    step(2);
    reset = 1'b1; bright = 4'd0; en_mask = 8'hFF; enable = 1'b1;
    step(600);

    repeat (40) begin
      en_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      bright  = 4'($urandom);
      enable  = ($urandom_range(0, 9) != 0);
      step($urandom_range(1, 150));
    end
    enable = 1'b1; en_mask = 8'h81; bright = 4'd5;
    step(300);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
